pc_sequencer: RTL and testbench

Program-counter sequencer for the accumulator processor: owns the architectural PC register and is the consumer of the PC+2 increment path. Each enabled cycle it selects the next PC from sequential (PC+2), branch target, call target, or return address, and maintains a small circular return-address stack (RAS). It sits between the control unit and instruction memory, driving the fetch address.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register with next-PC selection
// (sequential, conditional branch, call, return) and a circular
// return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_stall,
  input  logic [1:0]  i_pcsel,
  input  logic        i_cond,
  input  logic [15:0] i_target,
  input  logic        i_clrerr,
  output logic [15:0] o_pc,
  output logic        o_ras_empty,
  output logic        o_ras_full,
  output logic        o_ovf,
  output logic        o_unf
);

  localparam int            PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0]   C_DEPTH = (PW+1)'(RAS_DEPTH);
  localparam logic [1:0]    SEL_SEQ = 2'b00;
  localparam logic [1:0]    SEL_BR  = 2'b01;
  localparam logic [1:0]    SEL_CAL = 2'b10;
  localparam logic [1:0]    SEL_RET = 2'b11;

  logic [15:0]   r_pc;
  logic [PW-1:0] r_wp;
  logic [PW:0]   r_cnt;
  logic [15:0]   r_ras [RAS_DEPTH];
  logic          r_ovf;
  logic          r_unf;

  logic [15:0]   w_seq;
  logic [15:0]   w_tgt;
  logic [PW-1:0] w_wp_dec;
  logic [15:0]   w_pop_val;
  logic          w_empty;
  logic          w_full;
  logic [15:0]   w_pc_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  logic          w_unf_evt;

  assign w_seq     = r_pc + 16'd2;
  assign w_tgt     = {i_target[15:1], 1'b0};
  assign w_wp_dec  = r_wp - PW'(1);
  assign w_pop_val = r_ras[w_wp_dec];
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == C_DEPTH);

  // Next-PC selection and stack/flag events; stall suppresses every event.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (!i_stall) begin
      case (i_pcsel)
        SEL_SEQ: w_pc_nxt = w_seq;
        SEL_BR:  w_pc_nxt = i_cond ? w_tgt : w_seq;
        SEL_CAL: begin
          w_pc_nxt  = w_tgt;
          w_push    = 1'b1;
          w_ovf_evt = w_full;
        end
        SEL_RET: begin
          if (w_empty) begin
            w_pc_nxt  = w_seq;
            w_unf_evt = 1'b1;
          end else begin
            w_pc_nxt = w_pop_val;
            w_pop    = 1'b1;
          end
        end
        default: w_pc_nxt = w_seq;
      endcase
    end
  end

  // PC, pointer, count and sticky flags; reset overrides stall and all inputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_pc  <= RESET_PC;
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
        if (!w_full) r_cnt <= r_cnt + (PW+1)'(1);
      end else if (w_pop) begin
        r_wp  <= w_wp_dec;
        r_cnt <= r_cnt - (PW+1)'(1);
      end
      // A new error event outranks a same-cycle clear.
      if (w_ovf_evt)     r_ovf <= 1'b1;
      else if (i_clrerr) r_ovf <= 1'b0;
      if (w_unf_evt)     r_unf <= 1'b1;
      else if (i_clrerr) r_unf <= 1'b0;
    end
  end

  // Stack storage; contents need no reset, a full push overwrites the oldest entry.
  always_ff @(posedge i_clk) begin
    if (i_rstn && w_push) r_ras[r_wp] <= w_seq;
  end

  assign o_pc        = r_pc;
  assign o_ras_empty = w_empty;
  assign o_ras_full  = w_full;
  assign o_ovf       = r_ovf;
  assign o_unf       = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of vectors plus hand-built call/return,
// overflow, underflow, stall and reset sequences, checked through a queue.
module tb_pc_sequencer;

  logic        i_clk;
  logic        i_rstn;
  logic        i_stall;
  logic [1:0]  i_pcsel;
  logic        i_cond;
  logic [15:0] i_target;
  logic        i_clrerr;
  logic [15:0] o_pc;
  logic        o_ras_empty;
  logic        o_ras_full;
  logic        o_ovf;
  logic        o_unf;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_PC(16'h0000), .RAS_DEPTH(8)) u_dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_stall(i_stall), .i_pcsel(i_pcsel),
    .i_cond(i_cond), .i_target(i_target), .i_clrerr(i_clrerr),
    .o_pc(o_pc), .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full),
    .o_ovf(o_ovf), .o_unf(o_unf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rstn;
    logic        stall;
    logic [1:0]  pcsel;
    logic        cond;
    logic [15:0] target;
    logic        clrerr;
    logic [15:0] pc;
    logic        emp;
    logic        full;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic rstn, logic stall, logic [1:0] pcsel,
                              logic cond, logic [15:0] target, logic clrerr,
                              logic [15:0] pc, logic emp, logic full,
                              logic ovf, logic unf);
    vec_t v;
    v.rstn = rstn; v.stall = stall; v.pcsel = pcsel; v.cond = cond;
    v.target = target; v.clrerr = clrerr; v.pc = pc; v.emp = emp;
    v.full = full; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [15:0] act,
                     input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h required %h", nm, step, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge.
  task automatic apply(input vec_t v, input int step);
    vec_t e;
    i_rstn = v.rstn; i_stall = v.stall; i_pcsel = v.pcsel; i_cond = v.cond;
    i_target = v.target; i_clrerr = v.clrerr;
    exp_q.push_back(v);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard step %0d: queue empty", step);
    end else begin
      e = exp_q.pop_front();
      chk("pc",    step, o_pc,                 e.pc);
      chk("empty", step, {15'd0, o_ras_empty}, {15'd0, e.emp});
      chk("full",  step, {15'd0, o_ras_full},  {15'd0, e.full});
      chk("ovf",   step, {15'd0, o_ovf},       {15'd0, e.ovf});
      chk("unf",   step, {15'd0, o_unf},       {15'd0, e.unf});
    end
  endtask

  initial begin
    int s;
    s = 0;
    i_rstn = 1'b0; i_stall = 1'b0; i_pcsel = 2'b00; i_cond = 1'b0;
    i_target = 16'h0000; i_clrerr = 1'b0;

    // reset, sequential run, wrap-around, branches, nested call/return
    tbl.push_back(mk(0, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0002, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0004, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0006, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0008, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 16'hFFFD, 0, 16'hFFFC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'hFFFE, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 16'h1234, 0, 16'h0002, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 16'h1235, 0, 16'h1234, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 16'h0010, 0, 16'h0010, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 16'h0100, 0, 16'h0100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 0, 16'h0200, 0, 16'h0200, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 16'h0000, 0, 16'h0102, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 16'h0000, 0, 16'h0012, 1, 0, 0, 0));
    foreach (tbl[k]) begin
      apply(tbl[k], s);
      s++;
    end

    // overflow: 9 calls into a depth-8 stack, then 8 returns lose the oldest
    apply(mk(0, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0), s++);
    for (int i = 0; i < 9; i++) begin
      apply(mk(1, 0, 2'b10, 0, 16'((i + 1) * 16'h0100), 0,
               16'((i + 1) * 16'h0100), 0, (i >= 7), (i == 8), 0), s++);
    end
    for (int j = 0; j < 8; j++) begin
      apply(mk(1, 0, 2'b11, 0, 16'h0000, 0,
               16'((8 - j) * 16'h0100 + 2), (j == 7), 0, 1, 0), s++);
    end
    // clearing OVF while running sequentially
    apply(mk(1, 0, 2'b00, 0, 16'h0000, 1, 16'h0104, 1, 0, 0, 0), s++);

    // underflow, clear under stall, clear losing to a same-cycle event
    apply(mk(1, 0, 2'b01, 1, 16'h0040, 0, 16'h0040, 1, 0, 0, 0), s++);
    apply(mk(1, 0, 2'b11, 0, 16'h0000, 0, 16'h0042, 1, 0, 0, 1), s++);
    apply(mk(1, 1, 2'b11, 1, 16'h0777, 1, 16'h0042, 1, 0, 0, 0), s++);
    apply(mk(1, 0, 2'b11, 0, 16'h0000, 1, 16'h0044, 1, 0, 0, 1), s++);

    // stall with a call pending holds everything for 3 cycles
    for (int k = 0; k < 3; k++)
      apply(mk(1, 1, 2'b10, 0, 16'h0900, 0, 16'h0044, 1, 0, 0, 1), s++);

    // call immediately followed by return: no bubble, returns the call's SEQ
    apply(mk(1, 0, 2'b10, 0, 16'h0301, 0, 16'h0300, 0, 0, 0, 1), s++);
    apply(mk(1, 0, 2'b11, 0, 16'h0000, 0, 16'h0046, 1, 0, 0, 1), s++);

    // stalled with a non-empty stack, then reset beats stall and a pending call
    apply(mk(1, 0, 2'b10, 0, 16'h0500, 0, 16'h0500, 0, 0, 0, 1), s++);
    apply(mk(1, 1, 2'b11, 0, 16'h0000, 0, 16'h0500, 0, 0, 0, 1), s++);
    apply(mk(0, 1, 2'b10, 0, 16'h0600, 0, 16'h0000, 1, 0, 0, 0), s++);
    apply(mk(1, 0, 2'b11, 0, 16'h0000, 0, 16'h0002, 1, 0, 0, 1), s++);

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
